mem_stall_arbiter: RTL and testbench

//  Generates stall_pipeline, which the hazard unit consumes to freeze all pipeline registers and the PC.

---
 rtl/mem_stall_arbiter_if.sv | 39 +++
 rtl/mem_stall_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_stall_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stall_arbiter_if.sv
// Pipeline-side and memory-side handshake bundle for mem_stall_arbiter.
// master: the arbiter; slave: the pipeline/memory environment.
interface mem_stall_arbiter_if;
    // IF-stage fetch port
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    // MEM-stage data port
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_resp;
    // shared memory port
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_stall_arbiter.sv
// Shares one memory port between IF fetches and MEM loads/stores, stalling the
// pipeline until every request of the current pipeline cycle has completed and
// then releasing it for exactly one cycle.
module mem_stall_arbiter #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_stall_arbiter_if.master  bus,
    output logic                 stall_pipeline,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cycles
);

    typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I, RELEASE} state_t;

    state_t      state_q;
    logic        busy_q;        // a command is on the memory port awaiting completion
    logic [31:0] tmo_q;         // cycles spent waiting on the current command
    logic        i_done_q, d_done_q;
    logic        i_resp_q, d_resp_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        mem_read_q, mem_write_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wmask_q;
    logic        mem_err_q;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic        d_req, go_d, go_i, in_serve, issue_en, issue_d;
    logic        tmo_hit, complete;
    logic [31:0] rdata_in;

    assign d_req    = bus.d_read | bus.d_write;
    assign go_d     = d_req & ~d_done_q;
    assign go_i     = bus.i_read & ~i_done_q;
    assign in_serve = (state_q == SERVE_D) || (state_q == SERVE_I);

    // From IDLE the command goes out on the transition edge; moving between
    // SERVE states leaves one dead memory cycle before the next command.
    assign issue_en = ((state_q == IDLE) && (go_d || go_i)) || (in_serve && !busy_q);
    assign issue_d  = (state_q == IDLE) ? go_d : (state_q == SERVE_D);

    // A timeout is treated as a completion returning zero data.
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TIMEOUT);
    assign complete = busy_q && (bus.mem_resp || tmo_hit);
    assign rdata_in = bus.mem_resp ? bus.mem_rdata : 32'd0;

    assign stall_pipeline = (bus.i_read | d_req) & (state_q != RELEASE);

    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_resp    = i_resp_q;
    assign bus.d_resp    = d_resp_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign mem_err       = mem_err_q;
    assign stall_cycles  = stall_cycles_q;

    // Arbitration FSM with registered memory command, hold registers and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tmo_q       <= 32'd0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wmask_q <= 4'd0;
            mem_err_q   <= 1'b0;
        end else begin
            if (issue_en) begin
                // A data command with no request still present is issued as a
                // read so it can always complete; its data is simply unused.
                mem_read_q  <= issue_d ? !bus.d_write : 1'b1;
                mem_write_q <= issue_d & bus.d_write;
                mem_addr_q  <= issue_d ? bus.d_addr : bus.i_addr;
                mem_wdata_q <= (issue_d && bus.d_write) ? bus.d_wdata : 32'd0;
                mem_wmask_q <= (issue_d && bus.d_write) ? bus.d_wmask : 4'd0;
                busy_q      <= 1'b1;
                tmo_q       <= 32'd0;
            end else if (busy_q && !complete) begin
                tmo_q <= tmo_q + 32'd1;
            end

            if (complete) begin
                busy_q      <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (!bus.mem_resp) mem_err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (go_d)      state_q <= SERVE_D;
                    else if (go_i) state_q <= SERVE_I;
                end
                SERVE_D: begin
                    if (complete) begin
                        if (mem_read_q) d_rdata_q <= rdata_in;
                        d_done_q <= 1'b1;
                        if (go_i) begin
                            state_q <= SERVE_I;
                        end else begin
                            state_q  <= RELEASE;
                            d_resp_q <= 1'b1;
                            i_resp_q <= i_done_q;
                        end
                    end
                end
                SERVE_I: begin
                    if (complete) begin
                        i_rdata_q <= rdata_in;
                        i_done_q  <= 1'b1;
                        if (go_d) begin
                            state_q <= SERVE_D;
                        end else begin
                            state_q  <= RELEASE;
                            i_resp_q <= 1'b1;
                            d_resp_q <= d_done_q;
                        end
                    end
                end
                RELEASE: begin
                    i_resp_q <= 1'b0;
                    d_resp_q <= 1'b0;
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_pipeline && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // Performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

endmodule

// File: tb/tb_mem_stall_arbiter.sv
// Directed plus randomized transactions; expectations come from a
// transaction-level model of latency, hold data, error flag and stall count.
module tb_mem_stall_arbiter;
    localparam int TMO   = 8;
    localparam int CNTW  = 8;
    localparam int MAXC  = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_pipeline, mem_err;
    logic [CNTW-1:0] stall_cycles;

    mem_stall_arbiter_if bus();

    mem_stall_arbiter #(.TIMEOUT(TMO), .CNT_W(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .stall_pipeline(stall_pipeline), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] exp_i = 32'd0;
    logic [31:0] exp_d = 32'd0;
    logic        exp_err = 1'b0;
    int          exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_read = 0; bus.i_addr = 0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = 0;
        bus.d_wdata = 0; bus.d_wmask = 0;
        bus.mem_rdata = 0; bus.mem_resp = 0;
    endtask

    // One pipeline cycle's worth of requests, from the first stalled cycle
    // (cycle 0, DUT idle) through release and one trailing idle cycle.
    task automatic run_txn(input bit has_d, input bit is_st, input bit has_i, input bit tmo,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [3:0] wm,
                           input int nd, input int ni,
                           input logic [31:0] rd_d, input logic [31:0] rd_i);
        int n1, cmd1, resp1, cmd2, resp2, rel;
        logic [31:0] nxt_i, nxt_d;
        bit nxt_err;
        n1    = has_d ? nd : (tmo ? TMO : ni);
        cmd1  = 1;
        resp1 = cmd1 + n1;
        if (has_d && has_i) begin
            cmd2  = resp1 + 2;
            resp2 = cmd2 + ni;
            rel   = resp2 + 1;
        end else begin
            cmd2  = -10;
            resp2 = -10;
            rel   = resp1 + 1;
        end
        nxt_i   = has_i ? (tmo ? 32'd0 : rd_i) : exp_i;
        nxt_d   = (has_d && !is_st) ? rd_d : exp_d;
        nxt_err = exp_err | tmo;

        bus.i_read  = has_i;
        bus.i_addr  = ia;
        bus.d_read  = has_d & ~is_st;
        bus.d_write = has_d & is_st;
        bus.d_addr  = da;
        bus.d_wdata = wd;
        bus.d_wmask = wm;
        for (int c = 0; c <= rel; c++) begin
            if (c > 0) tick();
            bus.mem_resp  = !tmo && (c == resp1 || c == resp2);
            if (c == resp1)
                bus.mem_rdata = has_d ? (is_st ? $urandom : rd_d) : rd_i;
            else if (c == resp2)
                bus.mem_rdata = rd_i;
            else
                bus.mem_rdata = $urandom;
            @(negedge clk);
            chk("stall", stall_pipeline, (c < rel));
            if (c == 0) begin
                chk("i_rdata_hold", bus.i_rdata, exp_i);
                chk("d_rdata_hold", bus.d_rdata, exp_d);
            end
            if (c == cmd1) begin
                chk("cmd1_read",  bus.mem_read,  !(has_d && is_st));
                chk("cmd1_write", bus.mem_write, has_d && is_st);
                chk("cmd1_addr",  bus.mem_addr,  has_d ? da : ia);
                if (has_d && is_st) begin
                    chk("cmd1_wdata", bus.mem_wdata, wd);
                    chk("cmd1_wmask", bus.mem_wmask, wm);
                end
            end
            if (has_d && has_i && c == resp1 + 1)
                chk("gap_idle", bus.mem_read | bus.mem_write, 1'b0);
            if (c == cmd2) begin
                chk("cmd2_read", bus.mem_read, 1'b1);
                chk("cmd2_addr", bus.mem_addr, ia);
            end
            if (c == rel) begin
                exp_i   = nxt_i;
                exp_d   = nxt_d;
                exp_err = nxt_err;
                exp_cnt = (exp_cnt + rel > MAXC) ? MAXC : exp_cnt + rel;
                chk("i_resp",  bus.i_resp, has_i);
                chk("d_resp",  bus.d_resp, has_d);
                chk("i_rdata", bus.i_rdata, exp_i);
                chk("d_rdata", bus.d_rdata, exp_d);
                chk("mem_err", mem_err, exp_err);
                chk("stall_cycles", {24'd0, stall_cycles}, exp_cnt[31:0]);
                chk("cmd_dropped", bus.mem_read | bus.mem_write, 1'b0);
            end
        end
        // trailing idle cycle: requests gone, stray response must be ignored
        tick();
        clear_inputs();
        bus.mem_resp  = $urandom_range(0, 1);
        bus.mem_rdata = $urandom;
        @(negedge clk);
        chk("idle_stall", stall_pipeline, 1'b0);
        chk("idle_resp",  bus.i_resp | bus.d_resp, 1'b0);
        tick();
        bus.mem_resp = 0;
    endtask

    initial begin
        logic [31:0] a_i, a_d, w, r_d, r_i;
        int kind;
        clear_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", stall_pipeline, 1'b0);
        chk("rst_mem_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        chk("rst_err_cnt", {23'd0, mem_err, stall_cycles}, 32'd0);
        tick();
        rst_n = 1;

        // fetch only, memory answers 3 cycles after the command
        run_txn(0, 0, 1, 0, 32'h60, 0, 0, 0, 0, 3, 0, 32'h00A00093);
        // load and fetch in the same cycle
        run_txn(1, 0, 1, 0, 32'h64, 32'h100, 0, 0, 2, 4, 32'h12345678, 32'h00100113);
        // store: d_rdata must keep the previous load value
        run_txn(1, 1, 0, 0, 0, 32'h200, 32'hDEADBEEF, 4'b0011, 3, 0, 0, 0);

        // randomized mix; long enough to saturate the stall counter
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 4);
            a_i = {$urandom_range(0, 32'hFFFF), 2'b00};
            a_d = {$urandom_range(0, 32'hFFFF), 2'b00};
            w   = $urandom;
            r_d = $urandom;
            r_i = $urandom;
            case (kind)
                0: run_txn(0, 0, 1, 0, a_i, a_d, w, 4'hF, 1, $urandom_range(1, 5), r_d, r_i);
                1: run_txn(1, 0, 0, 0, a_i, a_d, w, 4'hF, $urandom_range(1, 5), 1, r_d, r_i);
                2: run_txn(1, 1, 0, 0, a_i, a_d, w, 4'($urandom_range(1, 15)), $urandom_range(1, 5), 1, r_d, r_i);
                3: run_txn(1, 0, 1, 0, a_i, a_d, w, 4'hF, $urandom_range(1, 5), $urandom_range(1, 5), r_d, r_i);
                default: run_txn(1, 1, 1, 0, a_i, a_d, w, 4'($urandom_range(1, 15)), $urandom_range(1, 5), $urandom_range(1, 5), r_d, r_i);
            endcase
        end

        // fetch that never gets a response
        run_txn(0, 0, 1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF);

        // reset in the middle of a load
        bus.d_read = 1;
        bus.d_addr = 32'h400;
        tick();
        @(negedge clk);
        chk("mid_cmd", bus.mem_read, 1'b1);
        bus.d_read = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_read", bus.mem_read, 1'b0);
        chk("mid_rst_stall", stall_pipeline, 1'b0);
        chk("mid_rst_err", mem_err, 1'b0);
        chk("mid_rst_cnt", {24'd0, stall_cycles}, 32'd0);
        chk("mid_rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        tick();
        rst_n = 1;
        bus.mem_resp  = 1;
        bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_resp = 0;
        @(negedge clk);
        chk("post_rst_ignored", bus.d_rdata | bus.i_rdata, 32'd0);
        chk("post_rst_stall", stall_pipeline, 1'b0);
        exp_i = 0; exp_d = 0; exp_err = 0; exp_cnt = 0;
        tick();
        run_txn(1, 0, 0, 0, 0, 32'h500, 0, 0, 2, 0, 32'hA5A5A5A5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
